// File: rtl/sgr_attr_engine.sv
// SGR attribute engine: turns the parser's per-parameter command stream into
// the committed rendition (colours and effect bits), with a save/restore stack.
module sgr_attr_engine #(
  parameter int CH_BITS = 3,
  parameter int SAVE_DEPTH = 4,
  parameter logic [3*CH_BITS-1:0] DEFAULT_FG = {3{CH_BITS'(((2**CH_BITS) - 1) * 5 / 7)}},
  parameter logic [3*CH_BITS-1:0] DEFAULT_BG = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  input  logic [2:0]                         cmd_op,
  input  logic [7:0]                         pn,
  output logic [3*CH_BITS-1:0]               fg,
  output logic [3*CH_BITS-1:0]               bg,
  output logic [3*CH_BITS-1:0]               ul_color,
  output logic                               ul_follow,
  output logic [6:0]                         effects,
  output logic                               attr_update,
  output logic                               stack_err,
  output logic [$clog2(SAVE_DEPTH+1)-1:0]    stack_level
);

  localparam int CW   = 3 * CH_BITS;
  localparam int LW   = $clog2(SAVE_DEPTH + 1);
  localparam int MAXC = (2 ** CH_BITS) - 1;
  localparam int NORM = MAXC * 5 / 7;

  typedef struct packed {
    logic [CW-1:0] fg;
    logic [CW-1:0] bg;
    logic [CW-1:0] ul;
    logic          follow;
    logic [6:0]    eff;
  } attr_t;

  typedef enum logic [2:0] {
    ST_START, ST_EXT_SEL, ST_EXT_IDX, ST_EXT_R, ST_EXT_G, ST_EXT_B
  } sub_state_e;

  typedef enum logic [1:0] {TGT_FG, TGT_BG, TGT_UL} target_e;

  localparam attr_t DEF_ATTR = '{fg: DEFAULT_FG, bg: DEFAULT_BG, ul: DEFAULT_FG,
                                 follow: 1'b1, eff: 7'd0};

  // Scale a level out of den onto the full channel range, rounding down.
  function automatic logic [CH_BITS-1:0] scale(input int num, input int den);
    return CH_BITS'(num * MAXC / den);
  endfunction

  // Eight-colour palette entry; index bit0 = R, bit1 = G, bit2 = B.
  function automatic logic [CW-1:0] basic(input logic [2:0] idx, input logic bright);
    logic [CH_BITS-1:0] v;
    logic [CH_BITS-1:0] z;
    v = bright ? CH_BITS'(MAXC) : CH_BITS'(NORM);
    z = '0;
    return {idx[0] ? v : z, idx[1] ? v : z, idx[2] ? v : z};
  endfunction

  // 256-colour palette: basic, bright, 6x6x6 cube, then grey ramp.
  function automatic logic [CW-1:0] pal256(input logic [7:0] n);
    int v;
    int k;
    v = int'({24'd0, n});
    k = v - 16;
    if (n < 8'd8)        return basic(n[2:0], 1'b0);
    else if (n < 8'd16)  return basic(n[2:0], 1'b1);
    else if (n < 8'd232) return {scale(k / 36, 5), scale((k / 6) % 6, 5), scale(k % 6, 5)};
    else                 return {3{scale(v - 232, 23)}};
  endfunction

  attr_t      com_q, com_d, wrk_q, wrk_d, step_attr, pop_attr;
  sub_state_e state_q, state_d, step_state;
  target_e    tgt_q, tgt_d, step_tgt;
  logic [LW-1:0] level_q, level_d;
  logic       upd_q, upd_d, err_q, err_d, push;
  logic [CW-1:0] col;
  logic       load;
  attr_t      stack_q [SAVE_DEPTH];

  // Result of applying one parameter to the working set in the current sub-state.
  always_comb begin
    step_attr  = wrk_q;
    step_state = ST_START;
    step_tgt   = tgt_q;
    load       = 1'b0;
    col        = (tgt_q == TGT_FG) ? wrk_q.fg : (tgt_q == TGT_BG) ? wrk_q.bg : wrk_q.ul;
    case (state_q)
      ST_START: begin
        if (pn == 8'd38)      begin step_state = ST_EXT_SEL; step_tgt = TGT_FG; end
        else if (pn == 8'd48) begin step_state = ST_EXT_SEL; step_tgt = TGT_BG; end
        else if (pn == 8'd58) begin step_state = ST_EXT_SEL; step_tgt = TGT_UL; end
        else if (pn == 8'd0)  step_attr = DEF_ATTR;
        else if (pn == 8'd1)  step_attr.eff[0] = 1'b1;
        else if (pn == 8'd22) step_attr.eff[0] = 1'b0;
        else if (pn == 8'd3)  step_attr.eff[4] = 1'b1;
        else if (pn == 8'd23) step_attr.eff[4] = 1'b0;
        else if (pn == 8'd4)  step_attr.eff[1] = 1'b1;
        else if (pn == 8'd24) step_attr.eff[1] = 1'b0;
        else if (pn == 8'd5)  step_attr.eff[2] = 1'b1;
        else if (pn == 8'd25) step_attr.eff[2] = 1'b0;
        else if (pn == 8'd7)  step_attr.eff[3] = 1'b1;
        else if (pn == 8'd27) step_attr.eff[3] = 1'b0;
        else if (pn == 8'd8)  step_attr.eff[6] = 1'b1;
        else if (pn == 8'd28) step_attr.eff[6] = 1'b0;
        else if (pn == 8'd9)  step_attr.eff[5] = 1'b1;
        else if (pn == 8'd29) step_attr.eff[5] = 1'b0;
        else if (pn >= 8'd30 && pn <= 8'd37)   step_attr.fg = basic(3'(pn - 8'd30), 1'b0);
        else if (pn >= 8'd40 && pn <= 8'd47)   step_attr.bg = basic(3'(pn - 8'd40), 1'b0);
        else if (pn >= 8'd90 && pn <= 8'd97)   step_attr.fg = basic(3'(pn - 8'd90), 1'b1);
        else if (pn >= 8'd100 && pn <= 8'd107) step_attr.bg = basic(3'(pn - 8'd100), 1'b1);
        else if (pn == 8'd39) step_attr.fg = DEFAULT_FG;
        else if (pn == 8'd49) step_attr.bg = DEFAULT_BG;
        else if (pn == 8'd59) step_attr.follow = 1'b1;
      end
      ST_EXT_SEL: begin
        if (pn == 8'd5)      step_state = ST_EXT_IDX;
        else if (pn == 8'd2) step_state = ST_EXT_R;
      end
      ST_EXT_IDX: begin
        col  = pal256(pn);
        load = 1'b1;
      end
      ST_EXT_R: begin
        col[CW-1 -: CH_BITS] = pn[7 -: CH_BITS];
        load       = 1'b1;
        step_state = ST_EXT_G;
      end
      ST_EXT_G: begin
        col[2*CH_BITS-1 -: CH_BITS] = pn[7 -: CH_BITS];
        load       = 1'b1;
        step_state = ST_EXT_B;
      end
      ST_EXT_B: begin
        col[CH_BITS-1:0] = pn[7 -: CH_BITS];
        load = 1'b1;
      end
      default: step_state = ST_START;
    endcase
    if (load) begin
      case (tgt_q)
        TGT_FG:  step_attr.fg = col;
        TGT_BG:  step_attr.bg = col;
        default: begin step_attr.ul = col; step_attr.follow = 1'b0; end
      endcase
    end
  end

  // Top entry of the stack, used by RESTORE.
  always_comb begin
    pop_attr = DEF_ATTR;
    for (int i = 0; i < SAVE_DEPTH; i++)
      if (level_q == LW'(i + 1)) pop_attr = stack_q[i];
  end

  // Command decode: working/committed updates, stack bookkeeping and pulses.
  always_comb begin
    com_d   = com_q;
    wrk_d   = wrk_q;
    state_d = state_q;
    tgt_d   = tgt_q;
    level_d = level_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        3'd1: begin wrk_d = com_q; state_d = ST_START; end
        3'd2: begin wrk_d = step_attr; state_d = step_state; tgt_d = step_tgt; end
        3'd3: begin
          wrk_d = step_attr; com_d = step_attr; tgt_d = step_tgt;
          state_d = ST_START; upd_d = 1'b1;
        end
        3'd4: begin wrk_d = DEF_ATTR; com_d = DEF_ATTR; state_d = ST_START; upd_d = 1'b1; end
        3'd5: begin
          if (level_q == LW'(SAVE_DEPTH)) err_d = 1'b1;
          else begin push = 1'b1; level_d = level_q + LW'(1); end
        end
        3'd6: begin
          if (level_q == '0) err_d = 1'b1;
          else begin
            com_d = pop_attr; wrk_d = pop_attr; state_d = ST_START;
            upd_d = 1'b1; level_d = level_q - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset restores defaults and abandons any open sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      com_q   <= DEF_ATTR;
      wrk_q   <= DEF_ATTR;
      state_q <= ST_START;
      tgt_q   <= TGT_FG;
      level_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      com_q   <= com_d;
      wrk_q   <= wrk_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
      level_q <= level_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; the committed set is written at the slot above the top.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SAVE_DEPTH; i++)
      if (!rst && push && level_q == LW'(i)) stack_q[i] <= com_q;
  end

  assign fg          = com_q.fg;
  assign bg          = com_q.bg;
  assign ul_color    = com_q.ul;
  assign ul_follow   = com_q.follow;
  assign effects     = com_q.eff;
  assign attr_update = upd_q;
  assign stack_err   = err_q;
  assign stack_level = level_q;

endmodule
